// File: rtl/commit_trace_pkg.sv
// Shared definitions for the commit trace streamer: record kinds, record layout,
// the captured bundle format and helpers used by the capture and emit logic.
package commit_trace_pkg;

  localparam logic [1:0] KIND_REG   = 2'd0;
  localparam logic [1:0] KIND_LOAD  = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;
  localparam logic [1:0] KIND_HALT  = 2'd3;

  localparam int REC_W        = 38;
  localparam int REC_DATA_LSB = 0;
  localparam int REC_ADDR_LSB = 16;
  localparam int REC_REG_LSB  = 32;
  localparam int REC_KIND_LSB = 36;

  // flags[k] marks that a record of kind k is present in the bundle
  typedef struct packed {
    logic [3:0]  flags;
    logic [3:0]  regDest;
    logic [15:0] wbData;
    logic [15:0] memAddr;
    logic [15:0] memWdata;
    logic [15:0] memRdata;
  } bundle_t;

  localparam int BUNDLE_W = $bits(bundle_t);

  typedef enum logic {
    CAP_RUN,
    CAP_HALTED
  } cap_state_t;

  typedef enum logic [1:0] {
    EM_IDLE,
    EM_EMIT,
    EM_DONE
  } emit_state_t;

  function automatic logic [1:0] firstKind(input logic [3:0] flags);
    if (flags[KIND_REG])        return KIND_REG;
    else if (flags[KIND_LOAD])  return KIND_LOAD;
    else if (flags[KIND_STORE]) return KIND_STORE;
    else                        return KIND_HALT;
  endfunction

  function automatic logic [REC_W-1:0] makeRecord(
    input logic [1:0]  kind,
    input logic [3:0]  regDest,
    input logic [15:0] wbData,
    input logic [15:0] memAddr,
    input logic [15:0] memWdata,
    input logic [15:0] memRdata,
    input logic [15:0] instCnt,
    input logic [15:0] cycleCnt
  );
    case (kind)
      KIND_REG:   return {kind, regDest, 16'h0000, wbData};
      KIND_LOAD:  return {kind, 4'h0, memAddr, memRdata};
      KIND_STORE: return {kind, 4'h0, memAddr, memWdata};
      default:    return {kind, 4'h0, instCnt, cycleCnt};
    endcase
  endfunction

endpackage

// File: rtl/trace_bundle_fifo.sv
// Synchronous FIFO of captured bundles. A push into a full FIFO is accepted
// only when a pop frees the slot in the same cycle.
module trace_bundle_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 72
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_pushData,
  input  logic                     i_pop,
  output logic                     o_pushOk,
  output logic [W-1:0]             o_head,
  output logic [W-1:0]             o_next,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic          w_doPop;
  logic          w_doPush;

  assign w_doPop  = i_pop && (r_count != '0);
  assign w_doPush = i_push && ((r_count != (AW+1)'(DEPTH)) || w_doPop);

  assign o_pushOk = w_doPush;
  assign o_head   = r_mem[r_rdPtr];
  assign o_next   = r_mem[r_rdPtr + AW'(1)];
  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/commit_trace_streamer.sv
// Captures per-cycle commit events into bundles, buffers them and streams one
// trace record per valid/ready handshake, ending with a HALT summary record.
module commit_trace_streamer
  import commit_trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reg_write,
  input  logic [3:0]       reg_dest,
  input  logic [15:0]      wb_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             halt,
  output logic             trc_valid,
  input  logic             trc_ready,
  output logic [REC_W-1:0] trc_data,
  output logic             trc_full,
  output logic             trc_overflow,
  output logic             trc_done
);
  localparam int AW = $clog2(FIFO_DEPTH);

  cap_state_t       r_capState, w_capNext;
  emit_state_t      r_emState, w_emNext;
  bundle_t          w_curBundle, w_pushData, r_haltBundle, w_head, w_next, w_src;
  logic             w_anyEvent, w_pushReq, w_pushOk, w_pop;
  logic             w_fifoFull, w_fifoEmpty;
  logic [AW:0]      w_fifoCount;
  logic             r_haltRetry, r_overflow;
  logic [CNT_W-1:0] r_instCount, r_cycleCount, r_dropCount;
  logic [15:0]      w_inst16, w_cyc16;
  logic             r_valid, w_validNext, w_load, w_hs;
  logic [REC_W-1:0] r_data, w_dataNext;
  logic [3:0]       r_pending, w_pendNext, w_remain, w_srcFlags;
  logic [1:0]       r_curKind, w_kindNext, w_selKind;

  assign w_anyEvent  = reg_write | mem_read | mem_write | halt;
  assign w_curBundle = '{flags:    {halt, mem_write, mem_read, reg_write},
                         regDest:  reg_dest,
                         wbData:   wb_data,
                         memAddr:  mem_addr,
                         memWdata: mem_wdata,
                         memRdata: mem_rdata};
  assign w_inst16 = 16'(r_instCount);
  assign w_cyc16  = 16'(r_cycleCount);

  trace_bundle_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BUNDLE_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_pushReq),
    .i_pushData (w_pushData),
    .i_pop      (w_pop),
    .o_pushOk   (w_pushOk),
    .o_head     (w_head),
    .o_next     (w_next),
    .o_full     (w_fifoFull),
    .o_empty    (w_fifoEmpty),
    .o_count    (w_fifoCount)
  );

  // Once halted, only a halt bundle that was refused for lack of space is pushed
  always_comb begin
    w_capNext  = r_capState;
    w_pushReq  = 1'b0;
    w_pushData = w_curBundle;
    case (r_capState)
      CAP_RUN: begin
        w_pushReq = w_anyEvent;
        if (halt) w_capNext = CAP_HALTED;
      end
      CAP_HALTED: begin
        w_pushReq  = r_haltRetry;
        w_pushData = r_haltBundle;
      end
      default: w_capNext = CAP_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_capState   <= CAP_RUN;
      r_haltRetry  <= 1'b0;
      r_haltBundle <= '0;
      r_overflow   <= 1'b0;
      r_instCount  <= '0;
      r_cycleCount <= '0;
      r_dropCount  <= '0;
    end else begin
      r_capState <= w_capNext;
      if (r_capState == CAP_RUN) begin
        if (r_cycleCount != '1) r_cycleCount <= r_cycleCount + CNT_W'(1);
        if ((halt || reg_write || mem_write) && (r_instCount != '1))
          r_instCount <= r_instCount + CNT_W'(1);
        if (w_pushReq && !w_pushOk) begin
          r_overflow <= 1'b1;
          if (r_dropCount != '1) r_dropCount <= r_dropCount + CNT_W'(1);
          if (halt) begin
            r_haltRetry  <= 1'b1;
            r_haltBundle <= w_curBundle;
          end
        end
      end else if (r_haltRetry && w_pushOk) begin
        r_haltRetry <= 1'b0;
      end
    end
  end

  assign w_hs = r_valid && trc_ready;

  // Source of the next record: the head bundle, its remaining flags, or the
  // following bundle when the head is popped and another is already queued
  always_comb begin
    w_emNext    = r_emState;
    w_validNext = r_valid;
    w_dataNext  = r_data;
    w_pendNext  = r_pending;
    w_kindNext  = r_curKind;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_src       = w_head;
    w_srcFlags  = w_head.flags;
    w_remain    = r_pending & ~(4'b0001 << r_curKind);
    case (r_emState)
      EM_IDLE: begin
        if (!w_fifoEmpty) begin
          w_emNext = EM_EMIT;
          w_load   = 1'b1;
        end
      end
      EM_EMIT: begin
        if (w_hs) begin
          if (r_curKind == KIND_HALT) begin
            w_pop       = 1'b1;
            w_emNext    = EM_DONE;
            w_validNext = 1'b0;
            w_dataNext  = '0;
          end else if (w_remain != 4'b0000) begin
            w_load     = 1'b1;
            w_srcFlags = w_remain;
          end else begin
            w_pop = 1'b1;
            if (w_fifoCount != (AW+1)'(1)) begin
              w_load     = 1'b1;
              w_src      = w_next;
              w_srcFlags = w_next.flags;
            end else begin
              w_emNext    = EM_IDLE;
              w_validNext = 1'b0;
            end
          end
        end
      end
      EM_DONE: begin
        w_validNext = 1'b0;
      end
      default: w_emNext = EM_IDLE;
    endcase
    w_selKind = firstKind(w_srcFlags);
    if (w_load) begin
      w_validNext = 1'b1;
      w_pendNext  = w_srcFlags;
      w_kindNext  = w_selKind;
      w_dataNext  = makeRecord(w_selKind, w_src.regDest, w_src.wbData, w_src.memAddr,
                               w_src.memWdata, w_src.memRdata, w_inst16, w_cyc16);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_emState <= EM_IDLE;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_pending <= '0;
      r_curKind <= KIND_REG;
    end else begin
      r_emState <= w_emNext;
      r_valid   <= w_validNext;
      r_data    <= w_dataNext;
      r_pending <= w_pendNext;
      r_curKind <= w_kindNext;
    end
  end

  assign trc_valid    = r_valid;
  assign trc_data     = r_data;
  assign trc_full     = w_fifoFull;
  assign trc_overflow = r_overflow;
  assign trc_done     = (r_emState == EM_DONE);

endmodule

// File: tb/tb_commit_trace_streamer.sv
// Scoreboard bench for commit_trace_streamer: drivers queue expected records,
// a negedge monitor pops and compares them on every handshake.
module tb_commit_trace_streamer;

  logic        clk;
  logic        rst_n;
  logic        reg_write;
  logic [3:0]  reg_dest;
  logic [15:0] wb_data;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        halt;
  logic        trc_valid;
  logic        trc_ready;
  logic [37:0] trc_data;
  logic        trc_full;
  logic        trc_overflow;
  logic        trc_done;

  int          checks;
  int          failures;
  logic [37:0] expQ[$];
  logic [37:0] expRec;

  commit_trace_streamer #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_write    (reg_write),
    .reg_dest     (reg_dest),
    .wb_data      (wb_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .halt         (halt),
    .trc_valid    (trc_valid),
    .trc_ready    (trc_ready),
    .trc_data     (trc_data),
    .trc_full     (trc_full),
    .trc_overflow (trc_overflow),
    .trc_done     (trc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: each handshake must match the oldest expected record
  always @(negedge clk) begin
    if (rst_n && trc_valid && trc_ready) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_record got=%h exp=none", trc_data);
      end else begin
        expRec = expQ.pop_front();
        if (trc_data !== expRec) begin
          failures++;
          $display("[TB] FAIL record got=%h exp=%h", trc_data, expRec);
        end
      end
    end
  end

  task automatic clearInputs();
    reg_write = 1'b0; reg_dest = 4'h0; wb_data = 16'h0;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = 16'h0;
    mem_wdata = 16'h0; mem_rdata = 16'h0; halt = 1'b0;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    expQ.delete();
  endtask

  // Drives one cycle of events (called at posedge+1), returns at next posedge+1
  task automatic driveCycle(input logic rw, input logic [3:0] rd, input logic [15:0] wd,
                            input logic mr, input logic mw, input logic [15:0] addr,
                            input logic [15:0] wdat, input logic [15:0] rdat,
                            input logic h, input logic expectRec);
    reg_write = rw; reg_dest = rd; wb_data = wd;
    mem_read = mr; mem_write = mw; mem_addr = addr;
    mem_wdata = wdat; mem_rdata = rdat; halt = h;
    if (expectRec) begin
      if (rw) expQ.push_back({2'b00, rd, 16'h0000, wd});
      if (mr) expQ.push_back({2'b01, 4'h0, addr, rdat});
      if (mw) expQ.push_back({2'b10, 4'h0, addr, wdat});
    end
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic test_reset();
    trc_ready = 1'b1;
    rst_n = 1'b0;
    reg_write = 1'b1; reg_dest = 4'h7; wb_data = 16'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (trc_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", trc_valid); end
    checks++; if (trc_data !== 38'h0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0", trc_data); end
    checks++; if (trc_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", trc_full); end
    checks++; if (trc_overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%b exp=0", trc_overflow); end
    checks++; if (trc_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", trc_done); end
    clearInputs();
    expQ.delete();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (trc_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_no_record got=%b exp=0", trc_valid); end
  endtask

  task automatic test_reg_store();
    trc_ready = 1'b1;
    driveCycle(1'b1, 4'd3, 16'h1234, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 16'h0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (trc_valid !== 1'b0) begin failures++; $display("[TB] FAIL latency_early got=%b exp=0", trc_valid); end
    @(negedge clk);
    checks++; if (trc_valid !== 1'b1) begin failures++; $display("[TB] FAIL latency_valid got=%b exp=1", trc_valid); end
    for (int k = 0; k < 20 && expQ.size() != 0; k++) @(posedge clk);
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL reg_store_drain left=%0d exp=0", expQ.size()); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_load_stall();
    logic [37:0] held;
    held = {2'b01, 4'h0, 16'h0010, 16'h00AA};
    trc_ready = 1'b0;
    driveCycle(1'b0, 4'h0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0, 16'h00AA, 1'b0, 1'b1);
    for (int k = 0; k < 10 && trc_valid !== 1'b1; k++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (trc_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid cyc=%0d got=%b exp=1", c, trc_valid); end
      checks++; if (trc_data !== held) begin failures++; $display("[TB] FAIL stall_data cyc=%0d got=%h exp=%h", c, trc_data, held); end
    end
    @(posedge clk);
    #1;
    trc_ready = 1'b1;
    for (int k = 0; k < 20 && expQ.size() != 0; k++) @(posedge clk);
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL load_drain left=%0d exp=0", expQ.size()); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    trc_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      driveCycle(1'b1, 4'(i), 16'h0100 + 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, i < 8);
      checks++; if (trc_full !== (i >= 7)) begin failures++; $display("[TB] FAIL bp_full push=%0d got=%b exp=%b", i + 1, trc_full, i >= 7); end
      checks++; if (trc_overflow !== (i == 8)) begin failures++; $display("[TB] FAIL bp_overflow push=%0d got=%b exp=%b", i + 1, trc_overflow, i == 8); end
    end
    trc_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (trc_full !== 1'b0) begin failures++; $display("[TB] FAIL bp_full_clear got=%b exp=0", trc_full); end
    for (int k = 0; k < 40 && expQ.size() != 0; k++) @(posedge clk);
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL bp_drain left=%0d exp=0", expQ.size()); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (trc_overflow !== 1'b1) begin failures++; $display("[TB] FAIL bp_sticky got=%b exp=1", trc_overflow); end
  endtask

  task automatic test_reset_midstream();
    trc_ready = 1'b0;
    driveCycle(1'b1, 4'd5, 16'h5555, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    for (int k = 0; k < 10 && trc_valid !== 1'b1; k++) @(negedge clk);
    checks++; if (trc_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_valid_before got=%b exp=1", trc_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (trc_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_valid got=%b exp=0", trc_valid); end
    checks++; if (trc_data !== 38'h0) begin failures++; $display("[TB] FAIL mid_reset_data got=%h exp=0", trc_data); end
    checks++; if (trc_overflow !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_overflow got=%b exp=0", trc_overflow); end
    expQ.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    trc_ready = 1'b1;
    driveCycle(1'b1, 4'd6, 16'h6666, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    for (int k = 0; k < 20 && expQ.size() != 0; k++) @(posedge clk);
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL mid_new_stream left=%0d exp=0", expQ.size()); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_halt();
    applyReset();
    trc_ready = 1'b1;
    rst_n = 1'b1;
    driveCycle(1'b1, 4'd1, 16'h0011, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    driveCycle(1'b1, 4'd2, 16'h0022, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    driveCycle(1'b1, 4'd3, 16'h0033, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    driveCycle(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
    expQ.push_back({2'b11, 4'h0, 16'd4, 16'd4});
    for (int i = 0; i < 3; i++)
      driveCycle(1'b1, 4'd9, 16'h9999, 1'b0, 1'b1, 16'h0900, 16'h0909, 16'h0, 1'b0, 1'b0);
    for (int k = 0; k < 20 && expQ.size() != 0; k++) @(posedge clk);
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL halt_drain left=%0d exp=0", expQ.size()); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (trc_done !== 1'b1) begin failures++; $display("[TB] FAIL halt_done got=%b exp=1", trc_done); end
    checks++; if (trc_valid !== 1'b0) begin failures++; $display("[TB] FAIL halt_valid got=%b exp=0", trc_valid); end
  endtask

  task automatic test_inst_count();
    applyReset();
    trc_ready = 1'b1;
    rst_n = 1'b1;
    driveCycle(1'b1, 4'd4, 16'h4444, 1'b0, 1'b1, 16'h0080, 16'hCAFE, 16'h0, 1'b0, 1'b1);
    driveCycle(1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 16'h0090, 16'h0, 16'h7777, 1'b0, 1'b1);
    driveCycle(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
    expQ.push_back({2'b11, 4'h0, 16'd2, 16'd3});
    for (int k = 0; k < 20 && expQ.size() != 0; k++) @(posedge clk);
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL inst_drain left=%0d exp=0", expQ.size()); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (trc_done !== 1'b1) begin failures++; $display("[TB] FAIL inst_done got=%b exp=1", trc_done); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    trc_ready = 1'b0;
    clearInputs();
    test_reset();
    test_reg_store();
    test_load_stall();
    test_backpressure();
    test_reset_midstream();
    test_halt();
    test_inst_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
